// File: rtl/comp_minmax_tracker.sv
// rtl/comp_minmax_tracker.sv - per-frame running max/min tracker with indices and beat count
// Optional build macro: MINMAX_TIE_LAST_EN (equal samples move the index, so the last occurrence wins)
module comp_minmax_tracker #(
  parameter int IN  = 16,
  parameter int CNT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IN-1:0]  in_data,
  input  logic           in_last,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [IN-1:0]  max_val,
  output logic [IN-1:0]  min_val,
  output logic [CNT-1:0] max_idx,
  output logic [CNT-1:0] min_idx,
  output logic [CNT-1:0] count,
  output logic           ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, state_nxt;
  logic   acc;
  logic   g_max, e_max, l_min, e_min;
  logic   sat;

  assign acc = in_valid && in_ready;

  // comparator decisions against the extremes held before this beat
  assign g_max = in_data >  max_val;
  assign e_max = in_data == max_val;
  assign l_min = in_data <  min_val;
  assign e_min = in_data == min_val;
  assign sat   = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (acc) state_nxt = in_last ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = rst_n;
        if (acc && in_last) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      min_val <= '0;
      max_idx <= '0;
      min_idx <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (acc) begin
      if (state == IDLE) begin
        max_val <= in_data;
        min_val <= in_data;
        max_idx <= '0;
        min_idx <= '0;
        count   <= {{(CNT-1){1'b0}}, 1'b1};
        ovf     <= 1'b0;
      end else begin
`ifdef MINMAX_TIE_LAST_EN
        if (g_max || e_max) begin
          max_val <= in_data;
          max_idx <= count;
        end
        if (l_min || e_min) begin
          min_val <= in_data;
          min_idx <= count;
        end
`else
        if (g_max) begin
          max_val <= in_data;
          max_idx <= count;
        end
        if (l_min) begin
          min_val <= in_data;
          min_idx <= count;
        end
`endif
        // count saturates at all-ones; the index captured there is all-ones too
        if (sat) ovf   <= 1'b1;
        else     count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comp_minmax_tracker.sv
// tb/tb_comp_minmax_tracker.sv - scoreboard bench for comp_minmax_tracker (CNT=4 to reach saturation)
module tb_comp_minmax_tracker;

  localparam int IN  = 16;
  localparam int CNT = 4;
  localparam int SAT = (1 << CNT) - 1;

  typedef struct packed {
    logic [IN-1:0]  mx;
    logic [IN-1:0]  mn;
    logic [CNT-1:0] mxi;
    logic [CNT-1:0] mni;
    logic [CNT-1:0] cnt;
    logic           ovf;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [IN-1:0]  in_data = '0;
  logic           in_last = 1'b0;
  logic           res_valid;
  logic           res_ready = 1'b1;
  logic [IN-1:0]  max_val, min_val;
  logic [CNT-1:0] max_idx, min_idx, count;
  logic           ovf;

  comp_minmax_tracker #(.IN(IN), .CNT(CNT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .max_val(max_val), .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx),
    .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_cyc = -1;
  int   acc0_cyc = -1;
  logic bp_en = 1'b0;
  logic rr_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic res_t act_res();
    return {max_val, min_val, max_idx, min_idx, count, ovf};
  endfunction

  function automatic logic [CNT-1:0] satc(input int k);
    return (k > SAT) ? CNT'(SAT) : CNT'(k);
  endfunction

  // reference: plain max/min over the frame, then locate the winning occurrence
  function automatic res_t model(input logic [IN-1:0] s[$]);
    res_t r;
    int   n = s.size();
    int   mi = -1, ni = -1;
    r.mx = s[0];
    r.mn = s[0];
    for (int k = 1; k < n; k++) begin
      if (s[k] > r.mx) r.mx = s[k];
      if (s[k] < r.mn) r.mn = s[k];
    end
    for (int k = 0; k < n; k++) begin
`ifdef MINMAX_TIE_LAST_EN
      if (s[k] == r.mx) mi = k;
      if (s[k] == r.mn) ni = k;
`else
      if (s[k] == r.mx && mi < 0) mi = k;
      if (s[k] == r.mn && ni < 0) ni = k;
`endif
    end
    r.mxi = satc(mi);
    r.mni = satc(ni);
    r.cnt = satc(n);
    r.ovf = (n > SAT);
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rr_hold) res_ready = bp_en ? (($urandom % 3) != 0) : 1'b1;
  end

  // monitor: checks held results for stability and pops the scoreboard on each handshake
  res_t held;
  logic held_v = 1'b0;
  res_t exp_r;
  always @(negedge clk) begin
    if (!rst_n) held_v = 1'b0;
    else if (res_valid) begin
      if (held_v) check("hold_stable", act_res(), held);
      if (res_ready) begin
        hs_cyc = cyc + 1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%h expected=none", act_res());
        end else begin
          exp_r = sb.pop_front();
          check("result", act_res(), exp_r);
        end
        held_v = 1'b0;
      end else begin
        held   = act_res();
        held_v = 1'b1;
      end
    end else held_v = 1'b0;
  end

  task automatic send_frame(input logic [IN-1:0] s[$], input int gap);
    int  n;
    bit  accepted;
    for (int k = 0; k < s.size(); k++) begin
      if (gap == 1 || (gap == 2 && ($urandom % 4) == 0)) begin
        in_valid = 1'b0;
        in_data  = IN'($urandom);
        in_last  = 1'b1;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = s[k];
      in_last  = (k == s.size() - 1);
      accepted = 1'b0;
      n = 0;
      while (!accepted) begin
        @(negedge clk);
        accepted = in_ready;
        if (accepted && k == 0) acc0_cyc = cyc + 1;
        @(posedge clk); #1;
        n++;
        if (n > 200) begin
          $display("FAIL accept_timeout actual=stalled expected=accept");
          $fatal(1, "accept timeout");
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    sb.push_back(model(s));
    check("latency_res_valid", res_valid, 1);
    check("done_in_ready", in_ready, 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || res_valid) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 400) begin
      $display("FAIL drain_timeout actual=%0d expected=0", sb.size());
      $fatal(1, "drain timeout");
    end
  endtask

  logic [IN-1:0] f[$];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_outputs", act_res(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    f = '{16'd3, 16'd9, 16'd1, 16'd9};
    send_frame(f, 0);
    f = '{16'hBEEF};
    send_frame(f, 0);
    f.delete();
    for (int i = 1; i <= 20; i++) f.push_back(IN'(i));
    send_frame(f, 0);
    drain();

    // backpressure: result held, a competing in_last beat must be ignored
    rr_hold   = 1'b1;
    res_ready = 1'b0;
    f = '{16'd4, 16'd4, 16'd8};
    send_frame(f, 0);
    in_valid = 1'b1;
    in_data  = 16'd77;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    f = '{16'd5, 16'd6};
    send_frame(f, 0);
    check("one_bubble", 64'(acc0_cyc - hs_cyc), 1);
    rr_hold = 1'b0;
    drain();

    // reset mid-frame discards the partial frame
    in_valid = 1'b1; in_data = 16'd100; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 16'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", act_res(), 0);
    check("midreset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    f = '{16'd5, 16'd2};
    send_frame(f, 0);

    f = '{16'd7, 16'hFFFF, 16'd0};
    send_frame(f, 1);
    drain();

    bp_en = 1'b1;
    for (int fr = 0; fr < 40; fr++) begin
      int n   = 1 + int'($urandom % 20);
      bit sml = ($urandom % 2) != 0;
      f.delete();
      for (int i = 0; i < n; i++) f.push_back(sml ? IN'($urandom % 6) : IN'($urandom));
      send_frame(f, 2);
    end
    drain();
    bp_en = 1'b0;
    check("scoreboard_empty", 64'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_minmax_tracker.md
Name: comp_minmax_tracker

Overview:
- Downstream consumer of the 16-bit magnitude comparator (g/l/e flags).
- Accepts a framed stream of unsigned samples over a valid/ready handshake.
- Keeps a running maximum and minimum for each frame, using the comparator's greater, less and equal decisions against the held extremes.
- Presents max, min, their sample indices and the beat count as one result per frame, also over valid/ready.

Parameters:
- IN, 16, sample width in bits (matches comparator IN).
- CNT, 8, width of the beat counter and of the index fields.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  IN  unsigned sample.
- in_last  input  1  beat is the final sample of its frame.
- res_valid  output  1  frame result available.
- res_ready  input  1  consumer takes the result.
- max_val  output  IN  largest sample of the frame.
- min_val  output  IN  smallest sample of the frame.
- max_idx  output  CNT  beat index (0-based) of max_val.
- min_idx  output  CNT  beat index of min_val.
- count  output  CNT  beats in the frame.
- ovf  output  1  frame exceeded 2^CNT-1 beats.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - State is IDLE, in_ready=0 during reset, res_valid=0.
  - max_val, min_val, max_idx, min_idx, count are all 0; ovf=0.
- A beat is accepted when in_valid && in_ready at a rising clk edge.
- States:
  - IDLE: in_ready=1. First accepted beat loads max_val=min_val=in_data, max_idx=min_idx=0, count=1, ovf=0. If in_last is set, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready=1. On each accepted beat, let i = current count (this beat's index):
    - in_data > max_val: max_val <= in_data, max_idx <= i.
    - in_data < min_val: min_val <= in_data, min_idx <= i.
    - Both comparisons use the held values from before this beat. Equal values leave the extremes and indices unchanged (the default tie-break keeps the first occurrence).
    - count <= count+1.
    - If in_last is set, go to DONE.
  - DONE: in_ready=0, res_valid=1. All result outputs are held stable while res_ready=0. On res_valid && res_ready, go to IDLE; res_valid is 0 the next cycle.
- Latency: res_valid rises the cycle after the in_last beat is accepted.
- Throughput: a new frame's first beat is accepted no earlier than the cycle after the result handshake (one bubble minimum).
- in_valid gaps inside a frame are legal. State holds, nothing updates.
- Result outputs keep their last values in IDLE until the next frame's first beat overwrites them.
- Saturation: when count is all-ones and another beat is accepted:
  - count holds at all-ones and ovf <= 1 (sticky until the next frame start).
  - max_val and min_val still update.
  - An index captured on such a beat is all-ones.
- All comparisons are unsigned, full IN width. No arithmetic beyond the CNT-bit increment.
- in_last on an ignored beat (in_ready=0) has no effect.
- rst_n asserted mid-frame or in DONE: immediate return to reset values. The partial frame is discarded and no result is produced.

Optional Feature:
- Macro: MINMAX_TIE_LAST_EN.
- Defined: ties update the index.
  - in_data == max_val: max_idx <= i.
  - in_data == min_val: min_idx <= i.
  - Values are unchanged; the last occurrence wins.
- Undefined: ties are ignored and the first occurrence wins.
- Port list is identical in both builds.

Test Plan:
- Frame 3,9,1,9(last), res_ready=1 -> max_val=9, max_idx=1 (3 with MINMAX_TIE_LAST_EN), min_val=1, min_idx=2, count=4, ovf=0; res_valid one cycle after the last beat.
- Single-beat frame 0xBEEF with in_last -> DONE next cycle: max=min=0xBEEF, both idx=0, count=1.
- Result backpressure: hold res_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, outputs stable; after the handshake, the next frame's first beat is accepted one cycle later.
- CNT=4, 20-beat frame of ascending values 1..20 -> count=15, ovf=1, max_val=20, max_idx=15, min_val=1, min_idx=0.
- Reset mid-frame after 2 beats, then a new frame 5,2(last) -> outputs reflect the new frame only: max 5 idx 0, min 2 idx 1, count 2.
- Frame 7,0xFFFF,0(last) with in_valid low on alternating cycles -> max 0xFFFF idx 1, min 0 idx 2, count 3; no extra beats counted.
